multicycle_control: RTL and testbench
=====================================

# multicycle_control

Main control FSM for the multi-cycle RISC-V core. It sequences the shared datapath (PC, instruction register, register file, single ALU, unified memory) through fetch/decode/execute/memory/write-back. It drives the 2-bit ALU-op code consumed by the ALU control decoder, handshakes with the memory port, and counts retired instructions.

## Interface
- No parameters; all encodings are fixed constants in `rv_ctrl_pkg`.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `opcode` in 7: IR[6:0]; valid from DECODE onward.
- `funct3` in 3: IR[14:12].
- `mem_ready` in 1: memory completes the current read/write this cycle.
- `pc_write`, `pc_write_cond`, `ir_write`, `reg_write` out 1 each: datapath write enables.
- `mem_req` out 1, `mem_we` out 1, `iord` out 1: memory request, write strobe, address select (0 = PC, 1 = ALUOut).
- `alu_src_a` out 2: 00 PC, 01 A reg, 10 zero, 11 old PC.
- `alu_src_b` out 2: 00 B reg, 01 const 4, 10 immediate.
- `aluop` out 2: 00 add, 01 sub, 10 R-type funct decode, 11 I-type funct decode.
- `pc_source` out 1: 0 ALU result, 1 ALUOut.
- `mem_to_reg` out 2: 00 ALUOut, 01 MDR, 10 PC.
- `illegal` out 1: trap indicator.
- `instret` out 32: retired-instruction count.
- `state` out 4: current state, for debug/7-seg.

## Operation
- Moore FSM; all control outputs decode from the state register only. Outputs not listed for a state are 0.
- FETCH: mem_req, iord=0, ir_write, alu_src_a=00, alu_src_b=01, aluop=00, pc_source=0. pc_write and ir_write assert only in a cycle where mem_ready=1; that cycle moves to DECODE. Otherwise the FSM stays in FETCH.
- DECODE: alu_src_a=11, alu_src_b=10, aluop=00 (ALUOut <= old PC + imm). Next state by opcode:
  - 0110011 → EXEC_R.
  - 0010011 → EXEC_I.
  - 0000011 / 0100011 → MEM_ADDR.
  - 1100011 → BRANCH if funct3=000, else TRAP.
  - 1101111 → JAL.
  - 0110111 → EXEC_LUI.
  - Any other opcode → TRAP.
- EXEC_R: src_a=01, src_b=00, aluop=10 → WB_ALU.
- EXEC_I: src_a=01, src_b=10, aluop=11 → WB_ALU.
- EXEC_LUI: src_a=10, src_b=10, aluop=00 → WB_ALU.
- WB_ALU: reg_write, mem_to_reg=00 → FETCH.
- MEM_ADDR: src_a=01, src_b=10, aluop=00 → MEM_RD for a load, MEM_WR for a store (opcode re-sampled).
- MEM_RD: mem_req, iord=1. Waits for mem_ready, then → WB_MEM.
- WB_MEM: reg_write, mem_to_reg=01 → FETCH.
- MEM_WR: mem_req, mem_we, iord=1. Waits for mem_ready, then → FETCH.
- BRANCH: src_a=01, src_b=00, aluop=01, pc_write_cond, pc_source=1 → FETCH.
- JAL: reg_write, mem_to_reg=10, pc_write, pc_source=1 → FETCH.
- TRAP: illegal=1, all enables 0. Absorbing; only reset exits.
- instret increments by 1 on every transition into FETCH from a non-FETCH state. It wraps modulo 2^32 and never increments in TRAP.

## Timing
- Reset (asynchronous): state=FETCH, instret=0. Outputs immediately take the FETCH decode: mem_req=1, iord=0, alu_src_b=01, all write enables 0.
- Reset asserted mid-instruction aborts it: no partial register, PC or memory write is issued after rst_n falls.
- Cycles per instruction with zero-wait memory (mem_ready held 1):
  - R-type, I-type, LUI: 4.
  - Load: 5.
  - Store: 4.
  - Branch, JAL: 3.
- Each memory wait cycle adds 1 in FETCH, MEM_RD or MEM_WR.
- mem_req stays asserted, with the address select stable, until the mem_ready cycle. A mem_ready outside those states is ignored.
- The first instruction's DECODE is at the earliest one cycle after reset release.

## Structure
- `rv_ctrl_pkg` holds:
  - the state enum (4-bit);
  - opcode constants;
  - ALU source, aluop, mem_to_reg and pc_source encodings.
- The ALU control decoder and the datapath both import `rv_ctrl_pkg`.
- Split into two pieces:
  - the next-state/output FSM in the top module;
  - sub-module `instret_counter`, a 32-bit counter with increment enable and async active-low reset.

## Test plan
- Reset: assert rst_n=0 mid-EXEC_R → state=FETCH, reg_write=0, instret=0 while low.
- add x3,x1,x2 (0x002081B3) with mem_ready=1 → FETCH, DECODE, EXEC_R (aluop=10), WB_ALU (reg_write=1) → instret=1 after 4 cycles.
- lw with mem_ready low for 3 cycles in MEM_RD → mem_req and iord=1 held 3 extra cycles; 8 cycles total; reg_write exactly once with mem_to_reg=01.
- beq (funct3=000) → 3 cycles, pc_write_cond=1 and aluop=01 in BRANCH. bne (funct3=001) → TRAP, illegal=1 persists 100 cycles, instret frozen.
- jal then lui → JAL asserts pc_write, reg_write and mem_to_reg=10 together; lui reaches WB_ALU with src_a=10; instret=2.
- instret preloaded (via force) to 0xFFFFFFFF, then one sw retires → instret=0x00000000.

Source files
------------

// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RISC-V control path: FSM states,
// opcodes, datapath mux selects and the ALU-op codes.
package rv_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_EXEC_R   = 4'd2,
    ST_EXEC_I   = 4'd3,
    ST_EXEC_LUI = 4'd4,
    ST_WB_ALU   = 4'd5,
    ST_MEM_ADDR = 4'd6,
    ST_MEM_RD   = 4'd7,
    ST_WB_MEM   = 4'd8,
    ST_MEM_WR   = 4'd9,
    ST_BRANCH   = 4'd10,
    ST_JAL      = 4'd11,
    ST_TRAP     = 4'd12
  } ctrl_state_e;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [2:0] F3_BEQ = 3'b000;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_A     = 2'b01;
  localparam logic [1:0] SRCA_ZERO  = 2'b10;
  localparam logic [1:0] SRCA_OLDPC = 2'b11;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE = 2'b11;

  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;

  localparam logic PCSRC_ALU    = 1'b0;
  localparam logic PCSRC_ALUOUT = 1'b1;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       ir_write;
    logic       reg_write;
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] aluop;
    logic       pc_source;
    logic [1:0] mem_to_reg;
    logic       illegal;
  } ctrl_out_t;

  // Only beq is implemented among branches; every other encoding traps.
  function automatic ctrl_state_e decode_next(input logic [6:0] opc,
                                              input logic [2:0] f3);
    ctrl_state_e nxt;
    case (opc)
      OP_RTYPE:  nxt = ST_EXEC_R;
      OP_ITYPE:  nxt = ST_EXEC_I;
      OP_LOAD:   nxt = ST_MEM_ADDR;
      OP_STORE:  nxt = ST_MEM_ADDR;
      OP_BRANCH: begin
        if (f3 == F3_BEQ) nxt = ST_BRANCH;
        else              nxt = ST_TRAP;
      end
      OP_JAL:    nxt = ST_JAL;
      OP_LUI:    nxt = ST_EXEC_LUI;
      default:   nxt = ST_TRAP;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/instret_counter.sv
// Retired-instruction counter: 32-bit, wraps modulo 2^32, async active-low reset.
module instret_counter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc_en,
  output logic [31:0] count
);

  logic [31:0] cnt_d;
  logic [31:0] cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_en) cnt_d = cnt_q + 32'd1;
    else        cnt_d = cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= 32'd0;
    else        cnt_q <= cnt_d;
  end

  assign count = cnt_q;

endmodule

// File: rtl/multicycle_control.sv
// Main Moore control FSM of the multi-cycle RISC-V core: sequences fetch,
// decode, execute, memory and write-back, and counts retired instructions.
module multicycle_control
  import rv_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        pc_write_cond,
  output logic        ir_write,
  output logic        reg_write,
  output logic        mem_req,
  output logic        mem_we,
  output logic        iord,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  aluop,
  output logic        pc_source,
  output logic [1:0]  mem_to_reg,
  output logic        illegal,
  output logic [31:0] instret,
  output logic [3:0]  state
);

  ctrl_state_e state_d;
  ctrl_state_e state_q;
  ctrl_out_t   ctrl;
  logic        inc_en;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH: begin
        if (mem_ready) state_d = ST_DECODE;
        else           state_d = ST_FETCH;
      end
      ST_DECODE:   state_d = decode_next(opcode, funct3);
      ST_EXEC_R:   state_d = ST_WB_ALU;
      ST_EXEC_I:   state_d = ST_WB_ALU;
      ST_EXEC_LUI: state_d = ST_WB_ALU;
      ST_WB_ALU:   state_d = ST_FETCH;
      // Opcode is re-sampled here; anything other than load/store is a corrupted IR.
      ST_MEM_ADDR: begin
        if (opcode == OP_LOAD)       state_d = ST_MEM_RD;
        else if (opcode == OP_STORE) state_d = ST_MEM_WR;
        else                         state_d = ST_TRAP;
      end
      ST_MEM_RD: begin
        if (mem_ready) state_d = ST_WB_MEM;
        else           state_d = ST_MEM_RD;
      end
      ST_WB_MEM:   state_d = ST_FETCH;
      ST_MEM_WR: begin
        if (mem_ready) state_d = ST_FETCH;
        else           state_d = ST_MEM_WR;
      end
      ST_BRANCH:   state_d = ST_FETCH;
      ST_JAL:      state_d = ST_FETCH;
      ST_TRAP:     state_d = ST_TRAP;
      default:     state_d = ST_TRAP;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_FETCH;
    else        state_q <= state_d;
  end

  // An instruction retires on each return to FETCH; TRAP never returns.
  assign inc_en = (state_q != ST_FETCH) && (state_d == ST_FETCH);

  instret_counter u_instret (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc_en (inc_en),
    .count  (instret)
  );

  always_comb begin
    ctrl = '0;
    case (state_q)
      ST_FETCH: begin
        ctrl.mem_req   = 1'b1;
        ctrl.iord      = 1'b0;
        ctrl.alu_src_a = SRCA_PC;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.aluop     = ALUOP_ADD;
        ctrl.pc_source = PCSRC_ALU;
        // rst_n gate keeps the fetch writes quiet while reset is held.
        ctrl.pc_write  = mem_ready & rst_n;
        ctrl.ir_write  = mem_ready & rst_n;
      end
      ST_DECODE: begin
        ctrl.alu_src_a = SRCA_OLDPC;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.aluop     = ALUOP_ADD;
      end
      ST_EXEC_R: begin
        ctrl.alu_src_a = SRCA_A;
        ctrl.alu_src_b = SRCB_B;
        ctrl.aluop     = ALUOP_RTYPE;
      end
      ST_EXEC_I: begin
        ctrl.alu_src_a = SRCA_A;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.aluop     = ALUOP_ITYPE;
      end
      ST_EXEC_LUI: begin
        ctrl.alu_src_a = SRCA_ZERO;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.aluop     = ALUOP_ADD;
      end
      ST_WB_ALU: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = M2R_ALUOUT;
      end
      ST_MEM_ADDR: begin
        ctrl.alu_src_a = SRCA_A;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.aluop     = ALUOP_ADD;
      end
      ST_MEM_RD: begin
        ctrl.mem_req = 1'b1;
        ctrl.iord    = 1'b1;
      end
      ST_WB_MEM: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = M2R_MDR;
      end
      ST_MEM_WR: begin
        ctrl.mem_req = 1'b1;
        ctrl.mem_we  = 1'b1;
        ctrl.iord    = 1'b1;
      end
      ST_BRANCH: begin
        ctrl.alu_src_a     = SRCA_A;
        ctrl.alu_src_b     = SRCB_B;
        ctrl.aluop         = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
      end
      ST_JAL: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = M2R_PC;
        ctrl.pc_write   = 1'b1;
        ctrl.pc_source  = PCSRC_ALUOUT;
      end
      ST_TRAP: begin
        ctrl.illegal = 1'b1;
      end
      default: begin
        ctrl.illegal = 1'b1;
      end
    endcase
  end

  assign pc_write      = ctrl.pc_write;
  assign pc_write_cond = ctrl.pc_write_cond;
  assign ir_write      = ctrl.ir_write;
  assign reg_write     = ctrl.reg_write;
  assign mem_req       = ctrl.mem_req;
  assign mem_we        = ctrl.mem_we;
  assign iord          = ctrl.iord;
  assign alu_src_a     = ctrl.alu_src_a;
  assign alu_src_b     = ctrl.alu_src_b;
  assign aluop         = ctrl.aluop;
  assign pc_source     = ctrl.pc_source;
  assign mem_to_reg    = ctrl.mem_to_reg;
  assign illegal       = ctrl.illegal;
  assign state         = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench for multicycle_control: each instruction is expanded into
// its expected per-cycle phase sequence and every cycle's outputs are compared.
module tb_multicycle_control;
  import rv_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        mem_ready;
  logic        pc_write, pc_write_cond, ir_write, reg_write;
  logic        mem_req, mem_we, iord, pc_source, illegal;
  logic [1:0]  alu_src_a, alu_src_b, aluop, mem_to_reg;
  logic [31:0] instret;
  logic [3:0]  state;
  logic [16:0] obs_ctrl;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_cnt;

  typedef enum int {K_R, K_I, K_LUI, K_LW, K_SW, K_BEQ, K_JAL, K_BNE, K_BAD} kind_e;

  multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .ir_write(ir_write),
    .reg_write(reg_write), .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .aluop(aluop), .pc_source(pc_source),
    .mem_to_reg(mem_to_reg), .illegal(illegal), .instret(instret), .state(state)
  );

  always #5 clk = ~clk;

  assign obs_ctrl = {pc_write, pc_write_cond, ir_write, reg_write, mem_req, mem_we, iord,
                     alu_src_a, alu_src_b, aluop, pc_source, mem_to_reg, illegal};

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected control word for a phase, straight from the per-state output table.
  function automatic logic [16:0] exp_ctrl(input ctrl_state_e st, input bit rdy);
    bit pw = 0, pwc = 0, irw = 0, rw = 0, mr = 0, we = 0, io = 0, ps = 0, il = 0;
    logic [1:0] sa = 2'b00, sb = 2'b00, op = 2'b00, m2r = 2'b00;
    case (st)
      ST_FETCH:    begin mr = 1; sb = 2'b01; pw = rdy; irw = rdy; end
      ST_DECODE:   begin sa = 2'b11; sb = 2'b10; end
      ST_EXEC_R:   begin sa = 2'b01; sb = 2'b00; op = 2'b10; end
      ST_EXEC_I:   begin sa = 2'b01; sb = 2'b10; op = 2'b11; end
      ST_EXEC_LUI: begin sa = 2'b10; sb = 2'b10; end
      ST_WB_ALU:   begin rw = 1; end
      ST_MEM_ADDR: begin sa = 2'b01; sb = 2'b10; end
      ST_MEM_RD:   begin mr = 1; io = 1; end
      ST_WB_MEM:   begin rw = 1; m2r = 2'b01; end
      ST_MEM_WR:   begin mr = 1; we = 1; io = 1; end
      ST_BRANCH:   begin sa = 2'b01; op = 2'b01; pwc = 1; ps = 1; end
      ST_JAL:      begin rw = 1; m2r = 2'b10; pw = 1; ps = 1; end
      ST_TRAP:     begin il = 1; end
      default:     begin il = 1; end
    endcase
    return {pw, pwc, irw, rw, mr, we, io, sa, sb, op, ps, m2r, il};
  endfunction

  function automatic bit is_legal_op(input logic [6:0] op);
    return op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                      7'b1100011, 7'b1101111, 7'b0110111};
  endfunction

  // One clock of stimulus; mem_ready is randomised wherever it must be ignored.
  task automatic cycle(input ctrl_state_e st, input bit rdy, input logic [6:0] op,
                       input logic [2:0] f3);
    bit memst;
    @(negedge clk);
    memst = (st == ST_FETCH) || (st == ST_MEM_RD) || (st == ST_MEM_WR);
    if (st == ST_FETCH) begin
      opcode = 7'($urandom);
      funct3 = 3'($urandom);
    end else begin
      opcode = op;
      funct3 = f3;
    end
    mem_ready = memst ? rdy : 1'($urandom_range(0, 1));
    #1;
    check_eq($sformatf("state_%s", st.name()), 32'(state), 32'(st));
    check_eq($sformatf("ctrl_%s", st.name()), 32'(obs_ctrl), 32'(exp_ctrl(st, rdy)));
    check_eq("instret", instret, model_cnt);
  endtask

  task automatic run_instr(input kind_e kind, input int wf, input int wm,
                           input logic [2:0] f3_in, input bit skip_fetch);
    ctrl_state_e seq[$];
    bit          rq[$];
    logic [6:0]  op;
    logic [2:0]  f3;
    f3 = f3_in;
    case (kind)
      K_R:     op = 7'b0110011;
      K_I:     op = 7'b0010011;
      K_LUI:   op = 7'b0110111;
      K_LW:    op = 7'b0000011;
      K_SW:    op = 7'b0100011;
      K_JAL:   op = 7'b1101111;
      K_BEQ:   begin op = 7'b1100011; f3 = 3'b000; end
      K_BNE:   begin op = 7'b1100011; f3 = 3'($urandom_range(1, 7)); end
      default: begin
        do op = 7'($urandom); while (is_legal_op(op));
      end
    endcase
    if (!skip_fetch) begin
      repeat (wf) begin seq.push_back(ST_FETCH); rq.push_back(1'b0); end
      seq.push_back(ST_FETCH); rq.push_back(1'b1);
    end
    seq.push_back(ST_DECODE); rq.push_back(1'b1);
    case (kind)
      K_R:   begin seq.push_back(ST_EXEC_R);   seq.push_back(ST_WB_ALU); end
      K_I:   begin seq.push_back(ST_EXEC_I);   seq.push_back(ST_WB_ALU); end
      K_LUI: begin seq.push_back(ST_EXEC_LUI); seq.push_back(ST_WB_ALU); end
      K_LW: begin
        seq.push_back(ST_MEM_ADDR);
        repeat (wm) begin seq.push_back(ST_MEM_RD); rq.push_back(1'b1); rq.push_back(1'b0); void'(rq.pop_back()); end
        seq.push_back(ST_MEM_RD);
        seq.push_back(ST_WB_MEM);
      end
      K_SW: begin
        seq.push_back(ST_MEM_ADDR);
        repeat (wm) seq.push_back(ST_MEM_WR);
        seq.push_back(ST_MEM_WR);
      end
      K_BEQ: seq.push_back(ST_BRANCH);
      K_JAL: seq.push_back(ST_JAL);
      default: repeat (100) seq.push_back(ST_TRAP);
    endcase
    // Ready flags after DECODE: memory phases wait wm cycles, then complete.
    rq.delete();
    if (!skip_fetch) begin
      repeat (wf) rq.push_back(1'b0);
      rq.push_back(1'b1);
    end
    rq.push_back(1'b1);
    for (int i = rq.size(); i < seq.size(); i++) begin
      if ((seq[i] == ST_MEM_RD || seq[i] == ST_MEM_WR) &&
          (i + 1 < seq.size()) && (seq[i + 1] == seq[i]))
        rq.push_back(1'b0);
      else
        rq.push_back(1'b1);
    end
    for (int i = 0; i < seq.size(); i++) cycle(seq[i], rq[i], op, f3);
    if (kind != K_BNE && kind != K_BAD) model_cnt = model_cnt + 32'd1;
  endtask

  // Asserts reset mid-cycle, holds it across edges, then releases with mem_ready low.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    mem_ready = 1'b1;
    #1;
    model_cnt = 32'd0;
    check_eq("rst_state", 32'(state), 32'(ST_FETCH));
    check_eq("rst_ctrl", 32'(obs_ctrl), 32'(exp_ctrl(ST_FETCH, 1'b0)));
    check_eq("rst_instret", instret, 32'd0);
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_hold_ctrl", 32'(obs_ctrl), 32'(exp_ctrl(ST_FETCH, 1'b0)));
    check_eq("rst_hold_instret", instret, 32'd0);
    rst_n = 1'b1;
    mem_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    mem_ready = 1'b1;
    opcode = 7'd0;
    funct3 = 3'd0;
    model_cnt = 32'd0;
    repeat (2) @(negedge clk);
    #1;
    check_eq("por_state", 32'(state), 32'(ST_FETCH));
    check_eq("por_ctrl", 32'(obs_ctrl), 32'(exp_ctrl(ST_FETCH, 1'b0)));
    check_eq("por_instret", instret, 32'd0);

    // Release with memory ready: DECODE follows on the very next edge.
    @(negedge clk);
    rst_n = 1'b1;
    mem_ready = 1'b1;
    #1;
    check_eq("first_fetch_ctrl", 32'(obs_ctrl), 32'(exp_ctrl(ST_FETCH, 1'b1)));
    run_instr(K_R, 0, 0, 3'b000, 1'b1);

    run_instr(K_LW, 0, 3, 3'b010, 1'b0);
    run_instr(K_BEQ, 0, 0, 3'b000, 1'b0);
    run_instr(K_JAL, 0, 0, 3'b000, 1'b0);
    run_instr(K_LUI, 0, 0, 3'b000, 1'b0);
    run_instr(K_SW, 2, 2, 3'b010, 1'b0);

    for (int n = 0; n < 80; n++) begin
      run_instr(kind_e'($urandom_range(0, 6)), $urandom_range(0, 2), $urandom_range(0, 3),
                3'($urandom), 1'b0);
    end

    // Reset landing in the middle of an R-type execute.
    cycle(ST_FETCH, 1'b1, 7'b0110011, 3'b000);
    cycle(ST_DECODE, 1'b1, 7'b0110011, 3'b000);
    cycle(ST_EXEC_R, 1'b1, 7'b0110011, 3'b000);
    do_reset();

    run_instr(K_I, 1, 0, 3'b100, 1'b0);
    run_instr(K_BNE, 0, 0, 3'b001, 1'b0);
    do_reset();
    run_instr(K_BAD, 1, 0, 3'b000, 1'b0);
    do_reset();

    // Counter wrap: preload all-ones while FETCH is stalled, then retire a store.
    @(negedge clk);
    mem_ready = 1'b0;
    force dut.u_instret.cnt_q = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.u_instret.cnt_q;
    model_cnt = 32'hFFFF_FFFF;
    run_instr(K_SW, 0, 0, 3'b010, 1'b0);
    cycle(ST_FETCH, 1'b0, 7'd0, 3'd0);
    check_eq("wrap_zero", instret, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
